// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the one-hot bus-select arbiter: state encoding,
// select-word convention and a small index helper.
package mux_sel_arbiter_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    // Encoding 2'd3 is unused; the FSM maps it back to IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_GRANT = GRANT,
        S_GAP   = GAP
    } state_t;

    // Select word: bit i drives source i onto the bus; all-zero means released.
    localparam bit SEL_RELEASED = 1'b0;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/select bundle between the sources and the arbiter; the arbiter
// side drives the select word, owner index and timeout pulse.
interface mux_sel_arbiter_if #(
    parameter int N_SRC = 2
);
    localparam int IDXW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] iReq;
    logic [N_SRC-1:0] oSelect;
    logic             oValid;
    logic [IDXW-1:0]  oOwner;
    logic             oTimeout;

    modport master (
        input  iReq,
        output oSelect,
        output oValid,
        output oOwner,
        output oTimeout
    );

    modport slave (
        output iReq,
        input  oSelect,
        input  oValid,
        input  oOwner,
        input  oTimeout
    );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping to the lowest set request otherwise.
module rr_pick #(
    parameter int N_SRC = 2,
    parameter int IDXW  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic [N_SRC-1:0] onehot,
    output logic [IDXW-1:0]  idx,
    output logic             any
);

    logic [N_SRC-1:0] upper;
    logic [N_SRC-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_mask
            assign upper[gi] = req[gi] & (IDXW'(gi) >= ptr);
        end
    endgenerate

    assign any  = |req;
    assign cand = (|upper) ? upper : req;

    // Scanning downward lets the lowest set candidate win.
    always_comb begin
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                idx = IDXW'(i);
            end
        end
    end

    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_onehot
            assign onehot[gi] = any & (idx == IDXW'(gi));
        end
    endgenerate

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner arbiter for a shared bus with grant-hold timeout and a
// one-cycle release gap; all outputs come straight from registers.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int N_SRC    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_sel_arbiter_if.master  bus
);

    localparam int IDXW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNTW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

    state_t           state_reg,   state_next;
    logic [CNTW-1:0]  cnt_reg,     cnt_next;
    logic [IDXW-1:0]  ptr_reg,     ptr_next;
    logic [IDXW-1:0]  owner_reg,   owner_next;
    logic [N_SRC-1:0] select_reg,  select_next;
    logic             valid_reg,   valid_next;
    logic             timeout_reg, timeout_next;

    logic [N_SRC-1:0] pick_onehot;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_any;
    logic             owner_req;

    rr_pick #(
        .N_SRC (N_SRC),
        .IDXW  (IDXW)
    ) u_pick (
        .req    (bus.iReq),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign owner_req = |(bus.iReq & select_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            ptr_reg     <= '0;
            owner_reg   <= '0;
            select_reg  <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ptr_reg     <= ptr_next;
            owner_reg   <= owner_next;
            select_reg  <= select_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = '0;
        ptr_next     = ptr_reg;
        owner_next   = '0;
        select_next  = {N_SRC{SEL_RELEASED}};
        valid_next   = 1'b0;
        timeout_next = 1'b0;

        case (state_reg)
            S_IDLE, S_GAP: begin
                if (pick_any) begin
                    state_next  = S_GRANT;
                    owner_next  = pick_idx;
                    select_next = pick_onehot;
                    valid_next  = 1'b1;
                    ptr_next    = IDXW'(wrap_inc(32'(pick_idx), N_SRC));
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_GRANT: begin
                // A release on the last allowed cycle is a normal release, not a timeout.
                if (!owner_req) begin
                    state_next = S_GAP;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next   = S_GAP;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next    = cnt_reg + CNTW'(1);
                    owner_next  = owner_reg;
                    select_next = select_reg;
                    valid_next  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.oSelect  = select_reg;
    assign bus.oValid   = valid_reg;
    assign bus.oOwner   = owner_reg;
    assign bus.oTimeout = timeout_reg;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with N_SRC=2, MAX_HOLD=16; outputs are
// sampled on the falling edge, inputs change right after it.
module tb_mux_sel_arbiter;

    localparam int N_SRC    = 2;
    localparam int MAX_HOLD = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_sel_arbiter_if #(.N_SRC(N_SRC)) bus ();

    mux_sel_arbiter #(
        .N_SRC    (N_SRC),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.iReq = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.iReq = 2'b11;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b00) begin
            errors++; $display("FAIL reset_select got %b want 00", bus.oSelect);
        end
        checks++;
        if (bus.oValid !== 1'b0 || bus.oOwner !== 1'b0 || bus.oTimeout !== 1'b0) begin
            errors++; $display("FAIL reset_flags got v=%b o=%b t=%b want 0 0 0", bus.oValid, bus.oOwner, bus.oTimeout);
        end
        rst_n    = 1'b1;
        bus.iReq = '0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single_grant();
        do_reset();
        @(negedge clk);
        bus.iReq = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b01 || bus.oOwner !== 1'b0 || bus.oValid !== 1'b1) begin
            errors++; $display("FAIL single_grant got sel=%b own=%b v=%b want 01 0 1", bus.oSelect, bus.oOwner, bus.oValid);
        end
        bus.iReq = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b00 || bus.oValid !== 1'b0 || bus.oTimeout !== 1'b0) begin
            errors++; $display("FAIL single_release got sel=%b v=%b t=%b want 00 0 0", bus.oSelect, bus.oValid, bus.oTimeout);
        end
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b00) begin
            errors++; $display("FAIL single_idle got sel=%b want 00", bus.oSelect);
        end
        $display("test_single_grant done");
    endtask

    task automatic test_release_gap();
        do_reset();
        bus.iReq = 2'b11;
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b01 || bus.oOwner !== 1'b0) begin
            errors++; $display("FAIL rg_first got sel=%b own=%b want 01 0", bus.oSelect, bus.oOwner);
        end
        bus.iReq = 2'b10;
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b00 || bus.oTimeout !== 1'b0) begin
            errors++; $display("FAIL rg_gap got sel=%b t=%b want 00 0", bus.oSelect, bus.oTimeout);
        end
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b10 || bus.oOwner !== 1'b1 || bus.oValid !== 1'b1) begin
            errors++; $display("FAIL rg_second got sel=%b own=%b v=%b want 10 1 1", bus.oSelect, bus.oOwner, bus.oValid);
        end
        $display("test_release_gap done");
    endtask

    task automatic test_gap_request();
        do_reset();
        bus.iReq = 2'b01;
        @(negedge clk);
        bus.iReq = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b00) begin
            errors++; $display("FAIL gapreq_gap got sel=%b want 00", bus.oSelect);
        end
        bus.iReq = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b01 || bus.oOwner !== 1'b0 || bus.oValid !== 1'b1) begin
            errors++; $display("FAIL gapreq_regrant got sel=%b own=%b v=%b want 01 0 1", bus.oSelect, bus.oOwner, bus.oValid);
        end
        $display("test_gap_request done");
    endtask

    task automatic test_timeout();
        logic [1:0] exp_sel;
        logic       exp_to;
        int         p;
        int         bad;
        do_reset();
        bus.iReq = 2'b01;
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            p       = (k - 1) % (MAX_HOLD + 1);
            exp_sel = (p < MAX_HOLD) ? 2'b01 : 2'b00;
            exp_to  = (p == MAX_HOLD);
            checks++;
            if (bus.oSelect !== exp_sel || bus.oTimeout !== exp_to) begin
                errors++; bad++;
                $display("FAIL timeout_cycle%0d got sel=%b t=%b want %b %b", k, bus.oSelect, bus.oTimeout, exp_sel, exp_to);
            end
        end
        bus.iReq = 2'b00;
        $display("test_timeout done (%0d bad cycles)", bad);
    endtask

    task automatic test_both_held();
        logic [1:0] exp_sel;
        logic       exp_own;
        logic       exp_to;
        int         p;
        int         bad;
        do_reset();
        bus.iReq = 2'b11;
        bad = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            p = (k - 1) % (2 * MAX_HOLD + 2);
            if (p < MAX_HOLD) begin
                exp_sel = 2'b01; exp_own = 1'b0; exp_to = 1'b0;
            end else if (p == MAX_HOLD) begin
                exp_sel = 2'b00; exp_own = 1'b0; exp_to = 1'b1;
            end else if (p < 2 * MAX_HOLD + 1) begin
                exp_sel = 2'b10; exp_own = 1'b1; exp_to = 1'b0;
            end else begin
                exp_sel = 2'b00; exp_own = 1'b0; exp_to = 1'b1;
            end
            checks++;
            if (bus.oSelect !== exp_sel || bus.oOwner !== exp_own || bus.oTimeout !== exp_to) begin
                errors++; bad++;
                $display("FAIL both_cycle%0d got sel=%b own=%b t=%b want %b %b %b",
                         k, bus.oSelect, bus.oOwner, bus.oTimeout, exp_sel, exp_own, exp_to);
            end
        end
        bus.iReq = 2'b00;
        $display("test_both_held done (%0d bad cycles)", bad);
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.iReq = 2'b11;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b00 || bus.oTimeout !== 1'b0 || bus.oValid !== 1'b0 || bus.oOwner !== 1'b0) begin
            errors++; $display("FAIL midreset_out got sel=%b t=%b v=%b own=%b want 00 0 0 0",
                               bus.oSelect, bus.oTimeout, bus.oValid, bus.oOwner);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b01 || bus.oOwner !== 1'b0) begin
            errors++; $display("FAIL midreset_ptr got sel=%b own=%b want 01 0", bus.oSelect, bus.oOwner);
        end
        bus.iReq = 2'b00;
        $display("test_reset_mid_grant done");
    endtask

    task automatic test_drop_at_limit();
        int bad;
        do_reset();
        bus.iReq = 2'b01;
        bad = 0;
        for (int k = 1; k <= MAX_HOLD; k++) begin
            @(negedge clk);
            checks++;
            if (bus.oSelect !== 2'b01) begin
                errors++; bad++;
                $display("FAIL limit_hold_cycle%0d got sel=%b want 01", k, bus.oSelect);
            end
        end
        bus.iReq = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b00 || bus.oTimeout !== 1'b0) begin
            errors++; $display("FAIL limit_drop got sel=%b t=%b want 00 0", bus.oSelect, bus.oTimeout);
        end
        @(negedge clk);
        checks++;
        if (bus.oSelect !== 2'b00 || bus.oTimeout !== 1'b0) begin
            errors++; $display("FAIL limit_idle got sel=%b t=%b want 00 0", bus.oSelect, bus.oTimeout);
        end
        $display("test_drop_at_limit done (%0d bad cycles)", bad);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.iReq = '0;
        test_reset();
        test_single_grant();
        test_release_gap();
        test_gap_request();
        test_timeout();
        test_both_held();
        test_reset_mid_grant();
        test_drop_at_limit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
